// File: rtl/pkt_disp_pkg.sv
// Shared types and default widths for the multi-channel packet dispatcher.
package pkt_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FWD  = 2'd1,
    DROP = 2'd2
  } state_e;

  localparam int unsigned DATA_W_DEF   = 32;
  localparam int unsigned NUM_CH_DEF   = 4;
  localparam int unsigned DEST_LSB_DEF = 24;
  localparam int unsigned DEST_W_DEF   = 4;
  localparam int unsigned CNT_W        = 16;

endpackage

// File: rtl/pkt_disp_sat_cnt.sv
// Saturating event counter with synchronous clear; used for dispatcher statistics.
module pkt_disp_sat_cnt
  import pkt_disp_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/packet_dispatcher_mc.sv
// Routes whole Avalon-ST packets to one of NUM_CH channels by a sop-beat destination field.
// Define PACKET_DISPATCHER_STATS_EN to add per-channel packet, drop and error counters.
module packet_dispatcher_mc
  import pkt_disp_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned NUM_CH   = NUM_CH_DEF,
  parameter int unsigned DEST_LSB = DEST_LSB_DEF,
  parameter int unsigned DEST_W   = DEST_W_DEF
) (
  input  logic                    clock_clk,
  input  logic                    reset_reset_n,
  input  logic [DATA_W-1:0]       snk_data,
  input  logic                    snk_valid,
  input  logic                    snk_sop,
  input  logic                    snk_eop,
  output logic                    snk_ready,
  output logic [DATA_W-1:0]       src_data,
  output logic                    src_sop,
  output logic                    src_eop,
  output logic [NUM_CH-1:0]       src_valid,
  input  logic [NUM_CH-1:0]       src_ready,
`ifdef PACKET_DISPATCHER_STATS_EN
  input  logic                    stats_clr,
  output logic [NUM_CH*CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0]        drop_count,
  output logic [CNT_W-1:0]        err_count,
`endif
  output logic                    drop_pulse
);

  localparam int unsigned      CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [DEST_W:0]  NUM_CH_X = (DEST_W+1)'(NUM_CH);

  state_e              state_q, state_d;
  logic [CH_W-1:0]     cur_ch_q, cur_ch_d;
  logic [DATA_W-1:0]   data_q;
  logic                sop_q, eop_q, drop_q;
  logic [NUM_CH-1:0]   valid_q;
  logic                push, drop_d, accept, pop;
  logic [CH_W-1:0]     push_ch;
  logic [DEST_W-1:0]   dest;
  logic                dest_ok;

  assign dest    = snk_data[DEST_LSB +: DEST_W];
  assign dest_ok = ((DEST_W+1)'(dest) < NUM_CH_X);
  assign pop     = |(valid_q & src_ready);

  // Ready while the output slot is empty or draining this cycle; drops never stall.
  assign snk_ready = reset_reset_n & ((state_q == DROP) | ~(|valid_q) | pop);
  assign accept    = snk_valid & snk_ready;

  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q  <= IDLE;
      cur_ch_q <= '0;
    end else begin
      state_q  <= state_d;
      cur_ch_q <= cur_ch_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cur_ch_d = cur_ch_q;
    push     = 1'b0;
    push_ch  = cur_ch_q;
    drop_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && snk_sop) begin
          if (dest_ok) begin
            push    = 1'b1;
            push_ch = CH_W'(dest);
            if (!snk_eop) begin
              cur_ch_d = CH_W'(dest);
              state_d  = FWD;
            end
          end else if (snk_eop) begin
            drop_d = 1'b1;
          end else begin
            state_d = DROP;
          end
        end
      end
      FWD: begin
        if (accept) begin
          push = 1'b1;
          if (snk_eop) state_d = IDLE;
        end
      end
      DROP: begin
        if (accept && snk_eop) begin
          drop_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Single output slot; a push in the same cycle as a pop reloads without a bubble.
  always_ff @(posedge clock_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      data_q  <= '0;
      sop_q   <= 1'b0;
      eop_q   <= 1'b0;
      valid_q <= '0;
      drop_q  <= 1'b0;
    end else begin
      drop_q <= drop_d;
      if (push) begin
        data_q  <= snk_data;
        sop_q   <= snk_sop;
        eop_q   <= snk_eop;
        valid_q <= NUM_CH'(1) << push_ch;
      end else if (pop) begin
        valid_q <= '0;
      end
    end
  end

  assign src_data   = data_q;
  assign src_sop    = sop_q;
  assign src_eop    = eop_q;
  assign src_valid  = valid_q;
  assign drop_pulse = drop_q;

`ifdef PACKET_DISPATCHER_STATS_EN
  logic [NUM_CH-1:0] eop_xfer_c;
  logic              err_c;

  assign eop_xfer_c = valid_q & src_ready & {NUM_CH{eop_q}};
  assign err_c      = accept & snk_sop & (state_q != IDLE);

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pkt_cnt
    pkt_disp_sat_cnt #(.W(CNT_W)) u_pkt_cnt (
      .clk   (clock_clk),
      .rst_n (reset_reset_n),
      .inc_i (eop_xfer_c[c]),
      .clr_i (stats_clr),
      .cnt_o (pkt_count[c*CNT_W +: CNT_W])
    );
  end

  pkt_disp_sat_cnt #(.W(CNT_W)) u_drop_cnt (
    .clk   (clock_clk),
    .rst_n (reset_reset_n),
    .inc_i (drop_d),
    .clr_i (stats_clr),
    .cnt_o (drop_count)
  );

  pkt_disp_sat_cnt #(.W(CNT_W)) u_err_cnt (
    .clk   (clock_clk),
    .rst_n (reset_reset_n),
    .inc_i (err_c),
    .clr_i (stats_clr),
    .cnt_o (err_count)
  );
`endif

endmodule

// File: tb/tb_packet_dispatcher_mc.sv
// Directed plus randomized bench for packet_dispatcher_mc against a packet-level reference model.
module tb_packet_dispatcher_mc;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] snk_data;
  logic        snk_valid, snk_sop, snk_eop, snk_ready;
  logic [31:0] src_data;
  logic        src_sop, src_eop, drop_pulse;
  logic [3:0]  src_valid, src_ready;
`ifdef PACKET_DISPATCHER_STATS_EN
  logic        stats_clr = 1'b0;
  logic [63:0] pkt_count;
  logic [15:0] drop_count, err_count;
`endif

  always #5 clk = ~clk;

  packet_dispatcher_mc dut (
    .clock_clk     (clk),
    .reset_reset_n (rst_n),
    .snk_data      (snk_data),
    .snk_valid     (snk_valid),
    .snk_sop       (snk_sop),
    .snk_eop       (snk_eop),
    .snk_ready     (snk_ready),
    .src_data      (src_data),
    .src_sop       (src_sop),
    .src_eop       (src_eop),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
`ifdef PACKET_DISPATCHER_STATS_EN
    .stats_clr     (stats_clr),
    .pkt_count     (pkt_count),
    .drop_count    (drop_count),
    .err_count     (err_count),
`endif
    .drop_pulse    (drop_pulse)
  );

  typedef struct {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    int          ch;
  } beat_t;

  // Reference model: beats awaiting delivery, and the route of the packet in progress
  // (-1 between packets, -2 discarding an unroutable packet, else the channel).
  beat_t q[$];
  int    route = -1;
  logic  drop_exp = 1'b0;
  int    m_pkt[4];
  int    m_drop = 0;
  int    m_err = 0;
  logic [3:0] rdy = 4'hF;
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int dest, input int payload);
    return {4'hA, 4'(dest), 24'(payload)};
  endfunction

  task automatic model_beat(input logic [31:0] d, input logic s, input logic e);
    int dest;
    beat_t b;
    dest = int'(d[27:24]);
    b.data = d; b.sop = s; b.eop = e;
    if (route == -1) begin
      if (s) begin
        if (dest < 4) begin
          b.ch = dest;
          q.push_back(b);
          if (!e) route = dest;
        end else if (e) begin
          drop_exp = 1'b1; m_drop++;
        end else begin
          route = -2;
        end
      end
    end else if (route >= 0) begin
      b.ch = route;
      q.push_back(b);
      if (s) m_err++;
      if (e) route = -1;
    end else begin
      if (s) m_err++;
      if (e) begin
        drop_exp = 1'b1; m_drop++; route = -1;
      end
    end
  endtask

  task automatic step(input logic v, input logic [31:0] d, input logic s, input logic e,
                      output logic acc);
    logic       exp_rdy;
    logic [3:0] exp_v;
    @(negedge clk);
    snk_valid = v; snk_data = d; snk_sop = s; snk_eop = e; src_ready = rdy;
    #1;
    exp_rdy = (route == -2) || (q.size() == 0) || rdy[q[0].ch];
    exp_v   = (q.size() != 0) ? 4'(1 << q[0].ch) : 4'b0;
    chk("snk_ready", 64'(snk_ready), 64'(exp_rdy));
    chk("src_valid", 64'(src_valid), 64'(exp_v));
    chk("drop_pulse", 64'(drop_pulse), 64'(drop_exp));
    if (q.size() != 0) begin
      chk("src_data", 64'(src_data), 64'(q[0].data));
      chk("src_sop", 64'(src_sop), 64'(q[0].sop));
      chk("src_eop", 64'(src_eop), 64'(q[0].eop));
    end
`ifdef PACKET_DISPATCHER_STATS_EN
    for (int c = 0; c < 4; c++)
      chk($sformatf("pkt_count%0d", c), 64'(pkt_count[c*16 +: 16]), 64'(m_pkt[c]));
    chk("drop_count", 64'(drop_count), 64'(m_drop));
    chk("err_count", 64'(err_count), 64'(m_err));
`endif
    drop_exp = 1'b0;
    if (q.size() != 0 && rdy[q[0].ch]) begin
      if (q[0].eop) m_pkt[q[0].ch]++;
      void'(q.pop_front());
    end
    acc = v & exp_rdy;
    if (acc) model_beat(d, s, e);
  endtask

  task automatic send(input logic [31:0] d, input logic s, input logic e);
    logic acc;
    int   n = 0;
    do begin
      step(1'b1, d, s, e, acc);
      n++;
    end while (!acc && n < 40);
    chk("send_accepted", 64'(acc), 64'd1);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 1'b0, acc);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; snk_valid = 1'b0; snk_sop = 1'b0; snk_eop = 1'b0;
    #1;
    chk("rst_src_valid", 64'(src_valid), 64'd0);
    chk("rst_snk_ready", 64'(snk_ready), 64'd0);
    chk("rst_drop_pulse", 64'(drop_pulse), 64'd0);
    chk("rst_src_sop", 64'(src_sop), 64'd0);
    q.delete(); route = -1; drop_exp = 1'b0;
    m_drop = 0; m_err = 0;
    for (int c = 0; c < 4; c++) m_pkt[c] = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic acc;
    int   dst;
    for (int c = 0; c < 4; c++) m_pkt[c] = 0;
    rst_n = 1'b0; snk_valid = 1'b0; snk_data = '0; snk_sop = 1'b0; snk_eop = 1'b0;
    src_ready = 4'hF;
    do_reset();

    // 3-beat packet to channel 2
    rdy = 4'hF;
    send(mk(2, 1), 1'b1, 1'b0);
    send(mk(2, 2), 1'b0, 1'b0);
    send(mk(2, 3), 1'b0, 1'b1);
    idle(3);

    // back-to-back single-beat packets, no bubble
    send(mk(0, 16), 1'b1, 1'b1);
    send(mk(3, 17), 1'b1, 1'b1);
    idle(2);

    // unroutable destination, 4 beats
    send(mk(7, 32), 1'b1, 1'b0);
    send(mk(7, 33), 1'b0, 1'b0);
    send(mk(7, 34), 1'b0, 1'b0);
    send(mk(7, 35), 1'b0, 1'b1);
    idle(2);

    // back-pressure on channel 1 for 5 cycles
    send(mk(1, 48), 1'b1, 1'b0);
    rdy = 4'b1101;
    for (int i = 0; i < 5; i++) begin
      step(1'b1, mk(1, 49), 1'b0, 1'b0, acc);
      chk("bp_stall", 64'(acc), 64'd0);
    end
    rdy = 4'hF;
    send(mk(1, 49), 1'b0, 1'b0);
    send(mk(1, 50), 1'b0, 1'b1);
    idle(2);

    // stray non-sop beats in idle, then a real packet
    send(32'hDEADBEEF, 1'b0, 1'b0);
    send(32'hDEADBEEF, 1'b0, 1'b0);
    send(mk(2, 64), 1'b1, 1'b0);
    send(mk(2, 65), 1'b0, 1'b1);
    idle(2);

    // reset in the middle of a channel-1 packet
    send(mk(1, 80), 1'b1, 1'b0);
    send(mk(1, 81), 1'b0, 1'b0);
    do_reset();
    send(mk(3, 96), 1'b1, 1'b0);
    send(mk(3, 97), 1'b0, 1'b1);
    idle(3);

    // randomized traffic with random per-channel back-pressure
    for (int i = 0; i < 600; i++) begin
      logic v, s, e;
      rdy = 4'($urandom) | 4'($urandom);
      v   = ($urandom_range(0, 3) != 0);
      s   = (route == -1) ? ($urandom_range(0, 4) != 0) : ($urandom_range(0, 9) == 0);
      e   = ($urandom_range(0, 2) == 0);
      dst = int'($urandom_range(0, 7));
      step(v, {4'($urandom), 4'(dst), 24'($urandom)}, s, e, acc);
    end
    rdy = 4'hF;
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
